// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: assembles a little-endian 32-bit word from four
// byte reads. Define ICACHE_EN to add a 32-entry direct-mapped instruction cache.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        pc_changed_i,
  input  logic        stall_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_rd_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic [1:0]  halt_type_o
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, RD4, OUT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        started_q, started_d;
  logic        gnt_q, gnt_d;
  logic        start;
  logic        cap_en;
  logic [1:0]  cap_idx;

`ifdef ICACHE_EN
  logic [31:0] cdata [32];
  logic [24:0] ctag  [32];
  logic [31:0] cvalid_q;
  logic        hit;
  logic        fill_we;

  assign hit = cvalid_q[pc_i[6:2]] && (ctag[pc_i[6:2]] == pc_i[31:7]);
`endif

  // Outside IDLE started_q is always 1, so only pc_changed_i can (re)start there.
  assign start = pc_changed_i | (ce_i & ~started_q);

  assign inst_o    = inst_q;
  assign inst_pc_o = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    started_d    = started_q;
    gnt_d        = 1'b0;
    cap_en       = 1'b0;
    cap_idx      = 2'd0;
    mem_rd_o     = 1'b0;
    mem_addr_o   = 32'd0;
    inst_valid_o = 1'b0;
    halt_type_o  = 2'b01;
`ifdef ICACHE_EN
    fill_we      = 1'b0;
`endif
    case (state_q)
      RD0: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = pc_q;
        gnt_d      = mem_grant_i;
        if (mem_grant_i) state_d = RD1;
      end
      RD1: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = pc_q + 32'd1;
        gnt_d      = mem_grant_i;
        cap_en     = gnt_q;
        cap_idx    = 2'd0;
        if (mem_grant_i) state_d = RD2;
      end
      RD2: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = pc_q + 32'd2;
        gnt_d      = mem_grant_i;
        cap_en     = gnt_q;
        cap_idx    = 2'd1;
        if (mem_grant_i) state_d = RD3;
      end
      RD3: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = pc_q + 32'd3;
        gnt_d      = mem_grant_i;
        cap_en     = gnt_q;
        cap_idx    = 2'd2;
        if (mem_grant_i) state_d = RD4;
      end
      RD4: begin
        cap_en  = gnt_q;
        cap_idx = 2'd3;
        state_d = OUT;
`ifdef ICACHE_EN
        fill_we = 1'b1;
`endif
      end
      OUT: begin
        inst_valid_o = 1'b1;
        halt_type_o  = stall_i ? 2'b10 : 2'b00;
        if (!stall_i) state_d = IDLE;
      end
      default: ;
    endcase

    // A byte arrives the cycle after its request was granted.
    if (cap_en) inst_d[{cap_idx, 3'b000} +: 8] = mem_data_i;

    // Restart wins over every other transition, including OUT -> IDLE.
    if (start) begin
      pc_d      = pc_i;
      started_d = 1'b1;
      state_d   = RD0;
      gnt_d     = 1'b0;
`ifdef ICACHE_EN
      fill_we   = 1'b0;
      if (hit) begin
        state_d = OUT;
        inst_d  = cdata[pc_i[6:2]];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= 32'd0;
      inst_q    <= 32'd0;
      started_q <= 1'b0;
      gnt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      started_q <= started_d;
      gnt_q     <= gnt_d;
    end
  end

`ifdef ICACHE_EN
  always_ff @(posedge clk) begin
    if (rst) cvalid_q <= 32'd0;
    else if (fill_we) cvalid_q[pc_q[6:2]] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_we) begin
      cdata[pc_q[6:2]] <= inst_d;
      ctag[pc_q[6:2]]  <= pc_q[31:7];
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: byte memory model, address/instruction
// scoreboards consumed by a negedge monitor. Build with ICACHE_EN for cache checks.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i, pc_changed_i, stall_i, mem_grant_i;
  logic [7:0]  mem_data_i;
  logic [31:0] mem_addr_o, inst_o, inst_pc_o;
  logic        mem_rd_o, inst_valid_o;
  logic [1:0]  halt_type_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] addr_q [$];
  logic [63:0] exp_q  [$];

  inst_fetch dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .pc_changed_i(pc_changed_i),
    .stall_i(stall_i), .mem_grant_i(mem_grant_i), .mem_data_i(mem_data_i),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o), .halt_type_o(halt_type_o)
  );

  always #5 clk = ~clk;

  // Bytes 0..3 hold 13 00 00 00; elsewhere byte = addr[7:0] + 0x10.
  function automatic logic [7:0] memb(input logic [31:0] a);
    if (a == 32'd0) return 8'h13;
    if (a < 32'd4)  return 8'h00;
    return a[7:0] + 8'h10;
  endfunction

  always @(posedge clk)
    mem_data_i <= (mem_rd_o && mem_grant_i) ? memb(mem_addr_o) : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd_o && mem_grant_i) begin
      if (addr_q.size() == 0) chk("unexpected_mem_req", mem_addr_o, 32'hDEAD_BEEF);
      else chk("mem_addr", mem_addr_o, addr_q.pop_front());
    end
    if (inst_valid_o && halt_type_o == 2'b00) begin
      if (exp_q.size() == 0) chk("unexpected_inst_pc", inst_pc_o, 32'hDEAD_BEEF);
      else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("inst", inst_o, e[31:0]);
        chk("inst_pc", inst_pc_o, e[63:32]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push4(input logic [31:0] pc);
    for (int k = 0; k < 4; k++) addr_q.push_back(pc + k);
  endtask

  // Called #1 after an edge with the block idle; returns at the negedge where
  // inst_valid_o is first seen, n = cycles since the start cycle. Grant is low
  // for cycles lo..hi (checking mem_addr_o==hold); at cycle ab_n pc jumps to ab_pc.
  task automatic run(input logic [31:0] pc, input bit chg, input int lo, input int hi,
                     input logic [31:0] hold, input int ab_n, input logic [31:0] ab_pc,
                     output int n);
    pc_i = pc;
    pc_changed_i = chg;
    n = 0;
    while (n < 40) begin
      @(posedge clk); n++; #1;
      pc_changed_i = (n == ab_n);
      if (n == ab_n) pc_i = ab_pc;
      mem_grant_i = !(n >= lo && n <= hi);
      @(negedge clk);
      if (n >= lo && n <= hi) chk("hold_addr", mem_addr_o, hold);
      if (inst_valid_o) break;
    end
    if (n >= 40) chk("valid_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; pc_i = 32'd0; ce_i = 1'b0; pc_changed_i = 1'b0;
    stall_i = 1'b0; mem_grant_i = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_rd", 32'(mem_rd_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_halt", 32'(halt_type_o), 32'd1);

    // ce-started fetch of address 0
    tick();
    rst = 1'b0; ce_i = 1'b1;
    push4(32'd0); exp_q.push_back({32'd0, 32'h0000_0013});
    run(32'd0, 1'b0, 0, 0, 32'd0, 0, 32'd0, n);
    chk("lat_basic", 32'(n), 32'd6);
    tick(); @(negedge clk);
    chk("after_out_valid", 32'(inst_valid_o), 32'd0);
    chk("after_out_halt", 32'(halt_type_o), 32'd1);

    // grant withheld 3 cycles in RD2
    tick();
    push4(32'h20); exp_q.push_back({32'h20, 32'h3332_3130});
    run(32'h20, 1'b1, 3, 5, 32'h22, 0, 32'd0, n);
    chk("lat_grant_stall", 32'(n), 32'd9);

    // abort in RD2: 0x42 request was granted before the jump
    tick();
    addr_q.push_back(32'h40); addr_q.push_back(32'h41); addr_q.push_back(32'h42);
    push4(32'h100); exp_q.push_back({32'h100, 32'h1312_1110});
    run(32'h40, 1'b1, 0, 0, 32'd0, 3, 32'h100, n);
    chk("lat_abort", 32'(n), 32'd9);

    // downstream stall in OUT, with address wrap
    tick();
    stall_i = 1'b1;
    push4(32'hFFFF_FFFE); exp_q.push_back({32'hFFFF_FFFE, 32'h0013_0F0E});
    run(32'hFFFF_FFFE, 1'b1, 0, 0, 32'd0, 0, 32'd0, n);
    chk("lat_wrap", 32'(n), 32'd6);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 32'(inst_valid_o), 32'd1);
      chk("stall_halt", 32'(halt_type_o), 32'd2);
      tick();
    end
    stall_i = 1'b0;
    @(negedge clk);
    chk("unstall_halt", 32'(halt_type_o), 32'd0);
    tick(); @(negedge clk);
    chk("unstall_idle", 32'(inst_valid_o), 32'd0);

    // reset in RD3 (request for 0x83 is still issued that cycle)
    tick();
    push4(32'h80);
    pc_i = 32'h80; pc_changed_i = 1'b1;
    tick(); pc_changed_i = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; ce_i = 1'b0;
    tick(); @(negedge clk);
    chk("rst_rd3_mem_rd", 32'(mem_rd_o), 32'd0);
    chk("rst_rd3_halt", 32'(halt_type_o), 32'd1);
    chk("rst_rd3_valid", 32'(inst_valid_o), 32'd0);
    tick(); @(negedge clk);
    chk("rst_hold_mem_rd", 32'(mem_rd_o), 32'd0);
    tick();
    rst = 1'b0; ce_i = 1'b1;
    push4(32'h100); exp_q.push_back({32'h100, 32'h1312_1110});
    run(32'h100, 1'b0, 0, 0, 32'd0, 0, 32'd0, n);
    chk("lat_after_rst", 32'(n), 32'd6);

    // fetch 0x40 twice; second is a hit when the cache is built in
    tick();
    push4(32'h40); exp_q.push_back({32'h40, 32'h5352_5150});
    run(32'h40, 1'b1, 0, 0, 32'd0, 0, 32'd0, n);
    chk("lat_0x40_first", 32'(n), 32'd6);
    tick();
`ifndef ICACHE_EN
    push4(32'h40);
`endif
    exp_q.push_back({32'h40, 32'h5352_5150});
    run(32'h40, 1'b1, 0, 0, 32'd0, 0, 32'd0, n);
`ifdef ICACHE_EN
    chk("lat_0x40_hit", 32'(n), 32'd1);
    chk("hit_mem_rd", 32'(mem_rd_o), 32'd0);
`else
    chk("lat_0x40_second", 32'(n), 32'd6);
`endif
    tick();
    rst = 1'b1; ce_i = 1'b0;
    tick();
    rst = 1'b0; ce_i = 1'b1;
    push4(32'h40); exp_q.push_back({32'h40, 32'h5352_5150});
    run(32'h40, 1'b1, 0, 0, 32'd0, 0, 32'd0, n);
    chk("lat_0x40_after_rst", 32'(n), 32'd6);
    tick(); tick();

    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
